// File: rtl/ccff_bitstream_loader.sv
// Serializes host configuration words MSB-first into a tile configuration chain,
// qualifies each chain shift with shift_en and accumulates parity of the returning tail.
module ccff_bitstream_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bit_count,
    output logic              tail_parity
);

    localparam int              WC_W   = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LP_LEN = CNT_W'(CHAIN_LEN);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WORD_W-1:0] r_shreg;
    logic [WC_W-1:0]   r_wcnt;
    logic [CNT_W-1:0]  r_bit_count;
    logic              r_head;
    logic              r_shift_en;
    logic              r_busy;
    logic              r_done;
    logic              r_parity;
    logic              w_last_bit;
    logic              w_word_end;

    // Bits of the next word that still fit in the chain; the tail of a partial word is dropped.
    function automatic logic [WC_W-1:0] f_word_bits(input logic [CNT_W-1:0] shifted);
        logic [CNT_W-1:0] remain;
        remain = LP_LEN - shifted;
        if (remain >= CNT_W'(WORD_W))
            return WC_W'(WORD_W);
        return WC_W'(remain);
    endfunction

    assign w_last_bit = (r_bit_count + CNT_W'(1)) == LP_LEN;
    assign w_word_end = r_wcnt == WC_W'(1);

    assign word_ready  = (r_state == S_FETCH) && !abort;
    assign ccff_head   = r_head;
    assign shift_en    = r_shift_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign bit_count   = r_bit_count;
    assign tail_parity = r_parity;

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (start) w_next = S_FETCH;
                S_FETCH:        if (word_valid) w_next = S_SHIFT;
                S_SHIFT: begin
                    if (w_last_bit)
                        w_next = S_DONE;
                    else if (w_word_end)
                        w_next = S_FETCH;
                end
                default:        w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state     <= S_IDLE;
            r_shreg     <= '0;
            r_wcnt      <= '0;
            r_bit_count <= '0;
            r_head      <= 1'b0;
            r_shift_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_parity    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_FETCH) || (w_next == S_SHIFT);
            if (abort) begin
                // Counters and parity are frozen for post-mortem inspection.
                r_shift_en <= 1'b0;
                r_done     <= 1'b0;
            end else begin
                r_shift_en <= 1'b0;
                if (r_shift_en)
                    r_parity <= r_parity ^ ccff_tail;
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (r_state == S_DONE)
                            r_done <= 1'b1;
                        if (start) begin
                            r_bit_count <= '0;
                            r_parity    <= 1'b0;
                            r_done      <= 1'b0;
                        end
                    end
                    S_FETCH: begin
                        if (word_valid) begin
                            r_shreg <= word_data;
                            r_wcnt  <= f_word_bits(r_bit_count);
                        end
                    end
                    S_SHIFT: begin
                        r_head      <= r_shreg[WORD_W-1];
                        r_shift_en  <= 1'b1;
                        r_shreg     <= r_shreg << 1;
                        r_bit_count <= r_bit_count + CNT_W'(1);
                        r_wcnt      <= r_wcnt - WC_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Configuration-chain driver that sits directly upstream of the I/O and logic grid tiles.
- Accepts configuration words from a host-side word stream and serializes them MSB-first onto ccff_head of the first tile's configuration chain.
- Generates a shift-enable that qualifies each shift edge of the external chain clock.
- Monitors ccff_tail returning from the last tile and reports parity of the previously stored configuration.

Parameters:
- WORD_W, 32, width of incoming configuration words.
- CHAIN_LEN, 1024, total number of configuration flops in the chain (bits to shift per load).
- CNT_W, 16, width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk  input  1  programming clock; all state on rising edge.
- pReset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; ignored unless state is IDLE or DONE.
- abort  input  1  returns to IDLE from any state on the next edge.
- word_valid  input  1  host word available.
- word_data  input  WORD_W  configuration word; bit WORD_W-1 is shifted first.
- word_ready  output  1  block accepts word_data this cycle when word_valid=1.
- ccff_head  output  1  serial configuration bit into the chain head.
- ccff_tail  input  1  serial bit returning from the chain tail.
- shift_en  output  1  chain clock-gate enable; high only when ccff_head carries a valid bit.
- busy  output  1  high in FETCH or SHIFT.
- done  output  1  high after exactly CHAIN_LEN bits are shifted; held until start or abort.
- bit_count  output  CNT_W  bits shifted so far in the current load.
- tail_parity  output  1  XOR of ccff_tail sampled on every shift_en cycle of the current load.

Behaviour:
- Clock and reset: one clock (prog_clk); asynchronous, active-high reset (pReset).
- Reset values: state=IDLE, word_ready=0, ccff_head=0, shift_en=0, busy=0, done=0, bit_count=0, tail_parity=0, shift register=0, word bit counter=0.
- Outputs: all outputs are registered except word_ready, which is decoded directly from state (word_ready = state==FETCH).
- IDLE/DONE:
  - On start: clear bit_count and tail_parity, clear done, go to FETCH.
  - start while busy=1 is ignored.
- FETCH:
  - shift_en=0; ccff_head holds its last value.
  - On word_valid&&word_ready: load the shift register with word_data, load the word-bit counter with min(WORD_W, CHAIN_LEN-bit_count), go to SHIFT.
  - No timeout while word_valid=0: the chain is simply not clocked.
- SHIFT, each cycle:
  - ccff_head <= shreg[WORD_W-1], shift_en <= 1, then shreg <<= 1.
  - bit_count increments.
  - tail_parity ^= ccff_tail, sampled in the same cycle as shift_en=1.
- SHIFT exit:
  - Word counter reaches 0 and bit_count < CHAIN_LEN: go to FETCH, and shift_en falls on the next cycle.
  - bit_count reaches CHAIN_LEN: go to DONE, done=1 on the cycle after the last shift_en.
- Latency: a word accepted at edge N produces its first valid ccff_head/shift_en pair during cycle N+1. Minimum one FETCH bubble between consecutive words.
- Partial final word: when CHAIN_LEN is not a multiple of WORD_W, only the top (CHAIN_LEN mod WORD_W) bits of the last word are shifted; the low bits are discarded.
- Overflow guard: bit_count never exceeds CHAIN_LEN, and no shift_en is produced after DONE.
- Abort: takes effect on the next edge from any state.
  - shift_en=0 immediately.
  - done=0, state=IDLE.
  - bit_count and tail_parity keep their last values for debug.
  - Chain content is undefined and must be reloaded.
- Simultaneous events:
  - abort wins over start and over word acceptance (word_ready is forced 0 that cycle).
  - start in DONE behaves like start in IDLE.
- pReset mid-load: immediate return to reset values; shift_en deasserts asynchronously.

Test Plan:
- Basic load (WORD_W=32, CHAIN_LEN=64):
  - Stimulus: start, then words 0xA5A5A5A5 and 0x0000FFFF.
  - Required: ccff_head sequence 1,0,1,0,0,1,0,1,... across 64 shift_en cycles; exactly one FETCH bubble; done=1 one cycle after the 64th shift; bit_count=64.
- Partial word (CHAIN_LEN=40):
  - Stimulus: words 0xFFFFFFFF then 0xC0FFFFFF.
  - Required: shifts 32 ones, then exactly 8 bits 1,1,0,0,0,0,0,0; 40 shift_en pulses total; the trailing 24 bits never appear.
- Backpressure:
  - Stimulus: word_valid low for 10 cycles in FETCH.
  - Required: shift_en=0 and ccff_head stable throughout; loading resumes with no bit lost.
- Tail parity:
  - Stimulus: drive ccff_tail with a model chain preloaded to 64 bits of alternating 1/0 plus one extra 1.
  - Required: tail_parity equals the XOR of the 64 sampled bits, i.e. 0 for 32 ones, 1 when an odd count is forced.
- Abort:
  - Stimulus: assert abort after the 10th shift.
  - Required: shift_en low next cycle, state IDLE, done=0, bit_count=10; a subsequent start reloads from bit_count=0.
- Reset and start while busy:
  - Stimulus: pulse pReset mid-SHIFT.
  - Required: all outputs at reset values asynchronously.
  - Stimulus: start asserted while busy.
  - Required: start ignored; the load completes unchanged.
